// File: rtl/esl_loader_pkg.sv
// +----------------------------------------------------------------------------+
// | esl_loader_pkg: shared FSM encoding and window address helpers.            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifndef INPUT_WIDTH
`define INPUT_WIDTH 4
`endif
`ifndef INPUT_WIDTH_LOG
`define INPUT_WIDTH_LOG 2
`endif
`ifndef INPUT_HEIGHT_LOG
`define INPUT_HEIGHT_LOG 2
`endif

package esl_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_READY = 2'd3
    } loader_state_t;

    // Row pitch of the zero-padded image: K-1 guard columns per row.
    function automatic int unsigned esl_pitch(input int unsigned k);
        return `INPUT_WIDTH + k - 1;
    endfunction

    function automatic int unsigned esl_slot(input int unsigned r, input int unsigned c,
                                             input int unsigned k);
        return r * k + c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/esl_window_addr_gen.sv
// +----------------------------------------------------------------------------+
// | esl_window_addr_gen: window fetch counters and read address/slot math.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module esl_window_addr_gen
    import esl_loader_pkg::*;
#(
    parameter int KERNEL_SIZE = 3,
    parameter int ADDR_WIDTH  = 16,
    parameter int W_WIDTH     = 2,
    parameter int H_WIDTH     = 2,
    parameter int SLOT_WIDTH  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  step_i,
    input  logic                  reuse_i,
    input  logic [W_WIDTH-1:0]    base_w_i,
    input  logic [H_WIDTH-1:0]    base_h_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [SLOT_WIDTH-1:0] slot_o,
    output logic                  last_o
);

    localparam int                   CNT_WIDTH = $clog2(KERNEL_SIZE + 1);
    localparam logic [CNT_WIDTH-1:0] K_LAST    = CNT_WIDTH'(KERNEL_SIZE - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [31:0]          PITCH     = 32'(esl_pitch(KERNEL_SIZE));

    logic [CNT_WIDTH-1:0] row_q, row_d;
    logic [CNT_WIDTH-1:0] col_q, col_d;
    logic [CNT_WIDTH-1:0] col_eff;

    // A reuse fetch walks only the rightmost column, top to bottom.
    assign col_eff = reuse_i ? K_LAST : col_q;
    assign last_o  = (row_q == K_LAST) && (reuse_i || (col_q == K_LAST));
    assign addr_o  = ADDR_WIDTH'((32'(base_h_i) + 32'(row_q)) * PITCH
                                 + 32'(base_w_i) + 32'(col_eff));
    assign slot_o  = SLOT_WIDTH'(esl_slot(32'(row_q), 32'(col_eff), KERNEL_SIZE));

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear_i) begin
            row_d = '0;
            col_d = '0;
        end else if (step_i) begin
            if (reuse_i || (col_q == K_LAST)) begin
                col_d = '0;
                row_d = row_q + CNT_ONE;
            end else begin
                col_d = col_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/esl_input_loader.sv
// +----------------------------------------------------------------------------+
// | esl_input_loader: fetches the KxK input window from padded image SRAM.     |
// | Optional column-shift reuse of the previous window: ESL_WINDOW_REUSE_EN.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module esl_input_loader
    import esl_loader_pkg::*;
#(
    parameter int KERNEL_SIZE = 3,
    parameter int PIXEL_WIDTH = 8,
    parameter int ADDR_WIDTH  = 16
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic                                        input_req,
    input  logic [`INPUT_WIDTH_LOG-1:0]                 width_index,
    input  logic [`INPUT_HEIGHT_LOG-1:0]                height_index,
    output logic                                        mem_rd_en,
    output logic [ADDR_WIDTH-1:0]                       mem_addr,
    input  logic [PIXEL_WIDTH-1:0]                      mem_rd_data,
    output logic [KERNEL_SIZE*KERNEL_SIZE*PIXEL_WIDTH-1:0] window_data,
    output logic                                        input_ready
);

    localparam int N          = KERNEL_SIZE * KERNEL_SIZE;
    localparam int WW         = `INPUT_WIDTH_LOG;
    localparam int HW         = `INPUT_HEIGHT_LOG;
    localparam int SLOT_WIDTH = (N > 1) ? $clog2(N) : 1;

    loader_state_t         state_q, state_d;
    logic [WW-1:0]         w_q, w_d;
    logic [HW-1:0]         h_q, h_d;
    logic                  reuse_q, reuse_d, reuse_now;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [SLOT_WIDTH-1:0] rd_slot_q, rd_slot_d;
    logic                  last_q, last_d;
    logic                  cap_en_q;
    logic [SLOT_WIDTH-1:0] cap_slot_q;
    logic [N*PIXEL_WIDTH-1:0] window_q;

    logic                  step, clear, shift;
    logic [WW-1:0]         gen_w;
    logic [HW-1:0]         gen_h;
    logic                  gen_reuse;
    logic [ADDR_WIDTH-1:0] gen_addr;
    logic [SLOT_WIDTH-1:0] gen_slot;
    logic                  gen_last;

`ifdef ESL_WINDOW_REUSE_EN
    logic          hist_valid_q;
    logic [WW:0]   w_next;

    // History becomes valid once a window has been fully assembled.
    always_ff @(posedge clock) begin
        if (reset) begin
            hist_valid_q <= 1'b0;
        end else if (state_q == ST_DRAIN) begin
            hist_valid_q <= 1'b1;
        end
    end

    assign w_next    = {1'b0, w_q} + (WW+1)'(1);
    assign reuse_now = hist_valid_q && ({1'b0, width_index} == w_next) && (height_index == h_q);
`else
    assign reuse_now = 1'b0;
`endif

    // The first read is issued straight from the request inputs in IDLE.
    assign gen_w     = (state_q == ST_IDLE) ? width_index  : w_q;
    assign gen_h     = (state_q == ST_IDLE) ? height_index : h_q;
    assign gen_reuse = (state_q == ST_IDLE) ? reuse_now    : reuse_q;
    assign step      = ((state_q == ST_IDLE) && input_req) || ((state_q == ST_ISSUE) && !last_q);
    assign clear     = !step && (state_q != ST_ISSUE);
    assign shift     = (state_q == ST_IDLE) && input_req && reuse_now;

    esl_window_addr_gen #(
        .KERNEL_SIZE (KERNEL_SIZE),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .W_WIDTH     (WW),
        .H_WIDTH     (HW),
        .SLOT_WIDTH  (SLOT_WIDTH)
    ) u_addr_gen (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (clear),
        .step_i   (step),
        .reuse_i  (gen_reuse),
        .base_w_i (gen_w),
        .base_h_i (gen_h),
        .addr_o   (gen_addr),
        .slot_o   (gen_slot),
        .last_o   (gen_last)
    );

    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        h_d       = h_q;
        reuse_d   = reuse_q;
        rd_en_d   = 1'b0;
        addr_d    = addr_q;
        rd_slot_d = rd_slot_q;
        last_d    = last_q;
        unique case (state_q)
            ST_IDLE: begin
                if (input_req) begin
                    state_d = ST_ISSUE;
                    w_d     = width_index;
                    h_d     = height_index;
                    reuse_d = reuse_now;
                end
            end
            ST_ISSUE: begin
                if (last_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = ST_READY;
            ST_READY: begin
                if (!input_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (step) begin
            rd_en_d   = 1'b1;
            addr_d    = gen_addr;
            rd_slot_d = gen_slot;
            last_d    = gen_last;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            w_q        <= '0;
            h_q        <= '0;
            reuse_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            addr_q     <= '0;
            rd_slot_q  <= '0;
            last_q     <= 1'b0;
            cap_en_q   <= 1'b0;
            cap_slot_q <= '0;
            window_q   <= '0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            h_q        <= h_d;
            reuse_q    <= reuse_d;
            rd_en_q    <= rd_en_d;
            addr_q     <= addr_d;
            rd_slot_q  <= rd_slot_d;
            last_q     <= last_d;
            cap_en_q   <= rd_en_q;
            cap_slot_q <= rd_slot_q;
            if (shift) begin
                for (int r = 0; r < KERNEL_SIZE; r++) begin
                    for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
                        window_q[(r*KERNEL_SIZE+c)*PIXEL_WIDTH +: PIXEL_WIDTH] <=
                            window_q[(r*KERNEL_SIZE+c+1)*PIXEL_WIDTH +: PIXEL_WIDTH];
                    end
                end
            end
            if (cap_en_q) begin
                window_q[cap_slot_q*PIXEL_WIDTH +: PIXEL_WIDTH] <= mem_rd_data;
            end
        end
    end

    assign mem_rd_en   = rd_en_q;
    assign mem_addr    = addr_q;
    assign window_data = window_q;
    assign input_ready = (state_q == ST_READY);

endmodule

`default_nettype wire

// File: tb/tb_esl_input_loader.sv
// +----------------------------------------------------------------------------+
// | tb_esl_input_loader: randomized request stream checked against a window   |
// | model; image memory returns mem[a] = a[7:0] one cycle after the strobe.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifndef INPUT_WIDTH
`define INPUT_WIDTH 4
`endif
`ifndef INPUT_WIDTH_LOG
`define INPUT_WIDTH_LOG 2
`endif
`ifndef INPUT_HEIGHT_LOG
`define INPUT_HEIGHT_LOG 2
`endif

module tb_esl_input_loader;

    localparam int K    = 3;
    localparam int PW   = 8;
    localparam int N    = K * K;
    localparam int AW   = 16;
    localparam int P    = `INPUT_WIDTH + K - 1;
    localparam int WMAX = (1 << `INPUT_WIDTH_LOG) - 1;
    localparam int HMAX = (1 << `INPUT_HEIGHT_LOG) - 1;
`ifdef ESL_WINDOW_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic                         clock = 1'b0;
    logic                         reset;
    logic                         input_req;
    logic [`INPUT_WIDTH_LOG-1:0]  width_index;
    logic [`INPUT_HEIGHT_LOG-1:0] height_index;
    logic                         mem_rd_en;
    logic [AW-1:0]                mem_addr;
    logic [PW-1:0]                mem_rd_data = '0;
    logic [N*PW-1:0]              window_data;
    logic                         input_ready;

    esl_input_loader #(.KERNEL_SIZE(K), .PIXEL_WIDTH(PW), .ADDR_WIDTH(AW)) dut (
        .clock        (clock),
        .reset        (reset),
        .input_req    (input_req),
        .width_index  (width_index),
        .height_index (height_index),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rd_data  (mem_rd_data),
        .window_data  (window_data),
        .input_ready  (input_ready)
    );

    always #5 clock = ~clock;

    // Image memory: garbage unless a read was strobed on the previous cycle.
    always @(posedge clock) mem_rd_data <= mem_rd_en ? mem_addr[7:0] : 8'($urandom);

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int start_cyc = 0;
    logic ready_prev = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    // Expected outputs for the current cycle.
    bit            chk_en = 1'b0;
    bit            exp_rd_en, exp_ready, exp_addr_chk, exp_win_chk;
    logic [AW-1:0] exp_addr;
    logic [N*PW-1:0] exp_win;

    // Model history.
    bit              hist_valid;
    int              pw, ph;
    logic [N*PW-1:0] model_win;

    task automatic chk(input string name, input logic [N*PW-1:0] act, input logic [N*PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("mem_rd_en", (N*PW)'(mem_rd_en), (N*PW)'(exp_rd_en));
            chk("input_ready", (N*PW)'(input_ready), (N*PW)'(exp_ready));
            if (exp_addr_chk) chk("mem_addr", (N*PW)'(mem_addr), (N*PW)'(exp_addr));
            if (exp_win_chk) chk("window_data", window_data, exp_win);
        end
        if (input_ready && !ready_prev) rise_cyc = cyc;
        ready_prev = input_ready;
    end

    function automatic logic [N*PW-1:0] model_window(input int w, input int h);
        logic [N*PW-1:0] v = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                v[(r*K+c)*PW +: PW] = PW'(((h + r) * P + w + c) % 256);
        return v;
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Starts in an idle cycle (becomes cycle 0); returns in the first idle cycle after READY.
    task automatic run_request(input int w, input int h, input int hold, input bit violate,
                               input int abort_at);
        int addrs[$];
        bit reuse;
        int nrd;
        reuse = REUSE && hist_valid && (w == pw + 1) && (h == ph);
        addrs = {};
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                if (!reuse || c == K - 1) addrs.push_back((h + r) * P + w + c);
        nrd = addrs.size();
        start_cyc    = cyc;
        input_req    = 1'b1;
        width_index  = `INPUT_WIDTH_LOG'(w);
        height_index = `INPUT_HEIGHT_LOG'(h);
        exp_rd_en = 1'b0; exp_ready = 1'b0; exp_addr_chk = 1'b0;
        exp_win = model_win; exp_win_chk = 1'b1;
        for (int i = 1; i <= nrd; i++) begin
            next_cycle();
            width_index  = `INPUT_WIDTH_LOG'($urandom);
            height_index = `INPUT_HEIGHT_LOG'($urandom);
            if (violate && i == 1) input_req = 1'b0;
            exp_rd_en = 1'b1; exp_addr = AW'(addrs[i-1]); exp_addr_chk = 1'b1; exp_win_chk = 1'b0;
            if (i == abort_at) begin
                reset = 1'b1;
                next_cycle();
                reset = 1'b0;
                model_win = '0;
                hist_valid = 1'b0;
                exp_rd_en = 1'b0; exp_ready = 1'b0; exp_addr_chk = 1'b0;
                exp_win = '0; exp_win_chk = 1'b1;
                chk("reset_mem_addr", (N*PW)'(mem_addr), '0);
                return;
            end
        end
        next_cycle();
        exp_rd_en = 1'b0; exp_addr_chk = 1'b0;
        next_cycle();
        model_win  = model_window(w, h);
        hist_valid = 1'b1; pw = w; ph = h;
        exp_ready = 1'b1; exp_win = model_win; exp_win_chk = 1'b1;
        if (!violate) begin
            for (int j = 0; j < hold; j++) next_cycle();
            input_req = 1'b0;
        end
        next_cycle();
        exp_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; input_req = 1'b0; width_index = '0; height_index = '0;
        hist_valid = 1'b0; pw = 0; ph = 0; model_win = '0;
        exp_rd_en = 1'b0; exp_ready = 1'b0; exp_addr = '0; exp_addr_chk = 1'b1;
        exp_win = '0; exp_win_chk = 1'b1;
        next_cycle();
        chk_en = 1'b1;
        next_cycle();
        reset = 1'b0;
        next_cycle();
        exp_addr_chk = 1'b0;

        run_request(0, 0, 0, 1'b0, 0);
        chk("latency_0_0", (N*PW)'(rise_cyc - start_cyc), (N*PW)'(11));
        chk("window_0_0", window_data, 72'h0e0d0c080706020100);

        run_request(1, 0, 0, 1'b0, 0);
        chk("latency_1_0", (N*PW)'(rise_cyc - start_cyc), (N*PW)'(REUSE ? 5 : 11));
        chk("window_1_0", window_data, 72'h0f0e0d090807030201);

        run_request(3, 0, 1, 1'b0, 0);
        run_request(0, 1, 0, 1'b0, 0);
        chk("window_0_1", window_data, 72'h1413120e0d0c080706);

        run_request(2, 2, 4, 1'b0, 0);
        run_request(1, 1, 0, 1'b1, 0);
        next_cycle();

        run_request(0, 0, 0, 1'b0, 4);
        run_request(0, 0, 0, 1'b0, 0);
        chk("latency_restart", (N*PW)'(rise_cyc - start_cyc), (N*PW)'(11));
        chk("window_restart", window_data, 72'h0e0d0c080706020100);

        for (int n = 0; n < 40; n++) begin
            int w, h;
            if (pw < WMAX && ($urandom % 2) == 0) begin
                w = pw + 1; h = ph;
            end else begin
                w = $urandom_range(0, WMAX); h = $urandom_range(0, HMAX);
            end
            run_request(w, h, $urandom_range(0, 3), ($urandom % 8) == 0, 0);
            repeat ($urandom_range(0, 2)) next_cycle();
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/esl_input_loader.md
# esl_input_loader

Responder side of the accelerator's input handshake. When the sequencing controller raises `input_req` for the current output pixel at (`width_index`, `height_index`), this block reads the K×K input window from a zero-padded, row-major image memory with synchronous reads. It assembles the window in registers and raises `input_ready` once the window is stable, so the PE array can latch it on init. It sits between the image SRAM and the PE/SNG datapath.

## Interface
Parameters:
- `KERNEL_SIZE`, default 3: window edge K; window holds N = K*K pixels.
- `PIXEL_WIDTH`, default 8: bits per pixel.
- `ADDR_WIDTH`, default 16: image memory address width.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `input_req` in 1: level request from the controller; held high until `input_ready` is seen.
- `width_index` in `` `INPUT_WIDTH_LOG ``: output column of the requested window.
- `height_index` in `` `INPUT_HEIGHT_LOG ``: output row of the requested window.
- `mem_rd_en` out 1: memory read strobe.
- `mem_addr` out ADDR_WIDTH: memory read address.
- `mem_rd_data` in PIXEL_WIDTH: read data, valid exactly 1 cycle after the strobe.
- `window_data` out N*PIXEL_WIDTH: element (r,c) at bits `[(r*K+c)*PIXEL_WIDTH +: PIXEL_WIDTH]`.
- `input_ready` out 1: window is valid and stable.

## Operation
- Padded row pitch P = `` `INPUT_WIDTH `` + K − 1. Address of (r,c) = (height_index + r)*P + (width_index + c), truncated to ADDR_WIDTH.
- Indices are sampled into internal registers on the IDLE→ISSUE transition. Later changes to the index inputs are ignored until the next request.
- FSM states:
  - IDLE: if `input_req`, go to ISSUE.
  - ISSUE: one read per cycle. Full fetch issues N reads in row-major order, r then c. Go to DRAIN after the last issue.
  - DRAIN: capture the final datum, then go to READY.
  - READY: `input_ready`=1. Go to IDLE on the first cycle `input_req`=0.
- Data captured in cycle t+1 is written to the window slot of the read issued in cycle t.
- `window_data` changes only while in ISSUE/DRAIN. It holds its value through READY and IDLE.
- If `input_req` drops during ISSUE/DRAIN (protocol violation), the fetch still completes. READY then lasts exactly 1 cycle.
- Reset values: state=IDLE, `input_ready`=0, `mem_rd_en`=0, `mem_addr`=0, `window_data`=0, reuse-valid flag=0.
- Reset asserted mid-fetch restores all reset values on the next edge. No partial window is kept. A request still held high restarts with a full fetch.

## Timing
- `mem_rd_en` and `mem_addr` are registered. They are high and valid exactly during the ISSUE cycles.
- Request sampled high in IDLE at cycle 0:
  - ISSUE occupies cycles 1..R, where R = N for a full fetch and K for a reuse fetch.
  - DRAIN occupies cycle R+1.
  - `input_ready` rises at cycle R+2.
- Full-fetch latency is N+2 cycles (11 for K=3).
- `input_ready` falls 1 cycle after `input_req` is sampled low. `input_req` is never high while `input_ready` is still high from a previous window.

## Configuration
- `ESL_WINDOW_REUSE_EN` defined:
  - The block keeps the last fetched indices and a valid flag.
  - A reuse fetch runs when the flag is set and the new request is (prev_w+1, prev_h). The window shifts left one column: column c takes column c+1. Then the K pixels of column K−1 are fetched, r = 0..K−1, addresses (h+r)*P + w + K − 1. Latency is K+2.
  - Every other request, and the first request after reset, does a full fetch.
- Undefined: every request does a full fetch, no index history is kept, and latency is always N+2.

## Structure
- Shared package `esl_loader_pkg`:
  - FSM state enum (IDLE, ISSUE, DRAIN, READY).
  - Function or constant for the padded pitch P.
  - Window slot index helper.
- One sub-module, `esl_window_addr_gen`, holds the fetch counters (r, c) and produces the address sequence for both fetch modes. It is combinational address math plus counter registers.

## Test plan
Common setup: K=3, `` `INPUT_WIDTH ``=4, so P=6. Memory model: mem[a] = a[7:0], 1-cycle read latency.
- Request (0,0), full fetch → addresses 0,1,2,6,7,8,12,13,14; window {0,1,2,6,7,8,12,13,14}; `input_ready` at cycle 11.
- Request (1,0) after (0,0), macro on → only addresses 3,9,15 read; window {1,2,3,7,8,9,13,14,15}; ready at cycle 5. Macro off → 9 reads, ready at cycle 11, same window.
- Request (0,1) after (3,0) → full fetch starting at address 6; window {6,7,8,12,13,14,18,19,20}.
- Handshake: hold `input_req` high 4 cycles into READY → `input_ready` stays high; drop req → ready low next cycle; window unchanged.
- Reset asserted at ISSUE cycle 4 with req held high → next cycle all outputs zero, state IDLE; then full fetch from address 0, ready 11 cycles after restart sampling.
